// File: rtl/rr_sel_arbiter.sv
// Four-channel round-robin arbiter driving the select of a downstream 4:1 mux.
// Grants are held until done, requester withdrawal, or a HOLD_MAX-cycle forced release.
module rr_sel_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned N_CH = 4;
    localparam int unsigned CW   = 2;
    localparam int unsigned HW   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_ptr;
    logic [CW-1:0]   w_ptr_nx;
    logic [CW-1:0]   r_sel;
    logic [CW-1:0]   w_sel_nx;
    logic [N_CH-1:0] r_gnt;
    logic [N_CH-1:0] w_gnt_nx;
    logic            r_busy;
    logic            w_busy_nx;
    logic            r_timeout;
    logic            w_timeout_nx;
    logic [HW-1:0]   r_hold;
    logic [HW-1:0]   w_hold_nx;

    logic            w_found;
    logic [CW-1:0]   w_pick;
    logic [CW-1:0]   w_idx;
    logic            w_keep;
    logic            w_limit;
    logic            w_release;

    // Rotating priority search: scanning from the far end lets the nearest hit win.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_idx = r_ptr + CW'(i);
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_keep    = req[r_sel];
    assign w_limit   = (r_hold == HW'(HOLD_MAX));
    assign w_release = done | ~w_keep | w_limit;

    // Next-state and registered-output values.
    always_comb begin
        w_state_nx   = r_state;
        w_ptr_nx     = r_ptr;
        w_sel_nx     = r_sel;
        w_gnt_nx     = r_gnt;
        w_busy_nx    = r_busy;
        w_timeout_nx = 1'b0;
        w_hold_nx    = r_hold;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nx  = '0;
                w_busy_nx = 1'b0;
                w_hold_nx = '0;
                if (w_found) begin
                    w_state_nx = ST_GRANT;
                    w_sel_nx   = w_pick;
                    w_gnt_nx   = N_CH'(1) << w_pick;
                    w_busy_nx  = 1'b1;
                    w_hold_nx  = HW'(1);
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nx   = ST_IDLE;
                    w_gnt_nx     = '0;
                    w_busy_nx    = 1'b0;
                    w_hold_nx    = '0;
                    w_ptr_nx     = CW'(r_sel + CW'(1));
                    // A forced release only counts as a timeout if nothing else ended the grant.
                    w_timeout_nx = w_limit & ~done & w_keep;
                end else begin
                    w_hold_nx = HW'(r_hold + HW'(1));
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_gnt_nx   = '0;
                w_busy_nx  = 1'b0;
                w_hold_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_ptr     <= w_ptr_nx;
            r_sel     <= w_sel_nx;
            r_gnt     <= w_gnt_nx;
            r_busy    <= w_busy_nx;
            r_timeout <= w_timeout_nx;
            r_hold    <= w_hold_nx;
        end
    end

    assign sel     = r_sel;
    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter (HOLD_MAX=4) with a model of the downstream 4:1 mux.
module tb_rr_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] mux_d;
    logic [3:0] exp_y;
    logic [3:0] exp_g;

    rr_sel_arbiter #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                           input logic e_busy, input logic e_to);
        chk({tag, ".gnt"},     gnt,           e_gnt);
        chk({tag, ".sel"},     {2'b00, sel},  {2'b00, e_sel});
        chk({tag, ".busy"},    {3'b000, busy},    {3'b000, e_busy});
        chk({tag, ".timeout"}, {3'b000, timeout}, {3'b000, e_to});
    endtask

    initial begin
        mux_d = 4'b1010;
        exp_y = 4'b1010;
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        tick();
        tick();
        chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Idle with no requests
        rst_n = 1'b1;
        req   = 4'b0000;
        tick();
        chk_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single requester ch2, then done
        req = 4'b0100;
        tick();
        chk_out("single.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("single.release", 4'b0000, 2'd2, 1'b0, 1'b0);
        done = 1'b0;

        // ptr is now 3: req=1001 grants ch3 first, then wraps to ch0
        req = 4'b1001;
        tick();
        chk_out("wrap.ch3", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("wrap.rel3", 4'b0000, 2'd3, 1'b0, 1'b0);
        done = 1'b0;
        tick();
        chk_out("wrap.ch0", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("wrap.rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 1'b0;

        // Fairness from ptr=0 after reset; mux output follows sel
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_g = 4'b0001 << (k % 4);
            chk_out("fair.grant", exp_g, 2'(k % 4), 1'b1, 1'b0);
            chk("fair.mux_y", {3'b000, mux_d[sel]}, {3'b000, exp_y[k % 4]});
            done = 1'b1;
            tick();
            chk_out("fair.idle", 4'b0000, 2'(k % 4), 1'b0, 1'b0);
            done = 1'b0;
        end

        // Timeout: ch1 alone held, other bits toggled mid-grant have no effect
        req = 4'b0010;
        tick();
        chk_out("to.c1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1011;
        tick();
        chk_out("to.c2", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0010;
        tick();
        chk_out("to.c3", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        chk_out("to.c4", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        chk_out("to.pulse", 4'b0000, 2'd1, 1'b0, 1'b1);
        tick();
        chk_out("to.regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

        // done coincides with the hold limit: release without timeout
        tick();
        tick();
        tick();
        chk_out("coin.c4", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("coin.release", 4'b0000, 2'd1, 1'b0, 1'b0);
        done = 1'b0;

        // Withdrawal releases at the next edge; sel holds while idle
        tick();
        chk_out("wd.grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("wd.release", 4'b0000, 2'd1, 1'b0, 1'b0);
        tick();
        chk_out("wd.idle_hold", 4'b0000, 2'd1, 1'b0, 1'b0);

        // ptr=2 after releasing ch1; then reset mid-grant
        req = 4'b1111;
        tick();
        chk_out("ptr2.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_out("rst.mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("rst.first", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_sel_arbiter.md
RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 15, the maximum number of cycles a single grant is held before a forced release (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port req  input  4  per-channel request; bit i = channel i.
REQ-005 SHALL have port done  input  1  the granted channel finishes; meaningful only while busy=1.
REQ-006 SHALL have port sel  output  2  the registered select; sel[1] drives S1 and sel[0] drives S0 of the downstream 4:1 mux.
REQ-007 SHALL have port gnt  output  4  the registered one-hot grant; all zero when idle.
REQ-008 SHALL have port busy  output  1  high while a grant is active.
REQ-009 SHALL have port timeout  output  1  a one-cycle pulse when a grant is force-released at HOLD_MAX.

Function
REQ-010 SHALL implement a two-state FSM with states IDLE and GRANT; all outputs SHALL be registered.
REQ-011 SHALL keep a 2-bit priority pointer ptr; the search order is ptr, ptr+1, ptr+2, ptr+3, all modulo 4.
REQ-012 In IDLE with req!=0 at an edge, the block SHALL grant the first requesting channel k in search order, enter GRANT, and set gnt=1<<k, sel=k and busy=1, all visible after that same edge (1-cycle latency).
REQ-013 In IDLE with req==0, the block SHALL remain in IDLE with gnt=0 and busy=0; sel SHALL hold its last value so the mux output stays stable.
REQ-014 In GRANT, a 4-bit hold counter SHALL start at 1 on the granting edge and increment by 1 at each edge the grant is retained.
REQ-015 In GRANT, the grant SHALL be released at an edge when any of these holds: done=1; req[sel]=0 (requester withdrew); or hold counter == HOLD_MAX.
REQ-016 On release, the block SHALL go to IDLE, clear gnt and busy, clear the hold counter, and set ptr=(sel+1) mod 4, wrapping from 3 to 0.
REQ-017 timeout SHALL pulse high for exactly the one cycle following a release caused only by the hold-counter limit (done=0 and req[sel]=1); if done=1 coincides with the limit, timeout SHALL stay 0.
REQ-018 Between any two consecutive grants there SHALL be exactly one IDLE cycle with gnt=0, so back-to-back requesters are granted every other cycle at best.
REQ-019 Changes to req[j] for j!=sel during GRANT SHALL have no effect until the next arbitration.
REQ-020 gnt SHALL always be zero or one-hot, and when busy=1, gnt SHALL equal 1<<sel.

Reset
REQ-021 At an edge with rst_n=0, the block SHALL enter IDLE and set ptr=0, sel=0, gnt=0, busy=0, timeout=0 and hold counter=0, regardless of state or inputs, including mid-grant.
REQ-022 Reset SHALL take priority over every other event at the same edge; the first arbitration SHALL be at the first edge with rst_n=1.

Verification
REQ-023 Single requester: req=0100 after reset -> next cycle gnt=0100, sel=10, busy=1; done=1 for one edge -> gnt=0000, ptr=3.
REQ-024 Fairness: req=1111 held, done pulsed once per grant -> grant order ch0,ch1,ch2,ch3,ch0, each followed by one idle cycle.
REQ-025 Timeout: HOLD_MAX=4, req=0010 held, done=0 -> gnt=0010 for exactly 4 cycles, then timeout=1 for 1 cycle with gnt=0, then ch1 re-granted.
REQ-026 Coincident events: done=1 at the same edge the counter reaches HOLD_MAX -> release with timeout=0; ptr=3 with req=1001 -> ch3 granted first, then ch0 (wrap).
REQ-027 Withdrawal and reset: drop req[sel] mid-grant -> release at the next edge; assert rst_n=0 mid-grant -> next cycle gnt=0, busy=0, sel=00, ptr=0.
REQ-028 Mux path: D=4'b1010 on the downstream 4:1 mux, channels granted in turn -> mux Y=0,1,0,1 for sel=0,1,2,3.
